// File: rtl/dcache_refill_bridge_if.sv
// AXI4 master port of the data-cache refill bridge: AR/R read channels and AW/W/B write channels.
interface dcache_refill_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/dcache_refill_bridge.sv
// Data-cache miss responder: optional victim writeback burst, 8-beat line fetch, one-cycle reload pulse.
// Define DCACHE_WB_PARALLEL_EN to overlap the victim writeback with the line fetch.
module dcache_refill_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rd_req,
    input  logic [31:0]            rd_addr,
    input  logic                   wr_req,
    input  logic [31:0]            wr_addr,
    input  logic [255:0]           cacheline_old,
    output logic                   reload,
    output logic [255:0]           cacheline_new,
    dcache_refill_bridge_if.master axi
);
    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RELOAD, S_RWAIT
    } state_t;

    state_t       state_q, state_d;
    state_t       wst;
    logic [31:0]  ar_addr_q, wb_addr_q;
    logic [255:0] wb_buf_q;
    logic [2:0]   wb_beat_q, rd_beat_q;
    logic [31:0]  wb_word [8];
    logic         accept, w_fire, r_fire;

    assign accept = (state_q == S_IDLE) && rd_req;
    assign w_fire = axi.wvalid && axi.wready;
    assign r_fire = axi.rready && axi.rvalid;

`ifdef DCACHE_WB_PARALLEL_EN
    // The write channels follow their own sub-FSM so the fetch never waits on the victim.
    state_t wr_state_q, wr_state_d;
    logic   wr_done;

    assign wst     = wr_state_q;
    assign wr_done = (wr_state_q == S_IDLE) || ((wr_state_q == S_B) && axi.bvalid);

    always_ff @(posedge clk) begin
        if (!resetn) wr_state_q <= S_IDLE;
        else         wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            S_IDLE:  if (accept && wr_req) wr_state_d = S_AW;
            S_AW:    if (axi.awready) wr_state_d = S_W;
            S_W:     if (w_fire && (wb_beat_q == 3'd7)) wr_state_d = S_B;
            S_B:     if (axi.bvalid) wr_state_d = S_IDLE;
            default: wr_state_d = S_IDLE;
        endcase
    end
`else
    assign wst = state_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
`ifdef DCACHE_WB_PARALLEL_EN
                    state_d = S_AR;
`else
                    state_d = wr_req ? S_AW : S_AR;
`endif
                end
            end
            S_AW:     if (axi.awready) state_d = S_W;
            S_W:      if (w_fire && (wb_beat_q == 3'd7)) state_d = S_B;
            S_B:      if (axi.bvalid) state_d = S_AR;
            S_AR:     if (axi.arready) state_d = S_R;
            S_R: begin
                if (r_fire && axi.rlast) begin
`ifdef DCACHE_WB_PARALLEL_EN
                    state_d = wr_done ? S_RELOAD : S_RWAIT;
`else
                    state_d = S_RELOAD;
`endif
                end
            end
            S_RWAIT: begin
`ifdef DCACHE_WB_PARALLEL_EN
                if (wr_done) state_d = S_RELOAD;
`else
                state_d = S_IDLE;
`endif
            end
            S_RELOAD: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        axi.arvalid = (state_q == S_AR);
        axi.rready  = (state_q == S_R);
        axi.awvalid = (wst == S_AW);
        axi.wvalid  = (wst == S_W);
        axi.wlast   = (wst == S_W) && (wb_beat_q == 3'd7);
        axi.bready  = (wst == S_B);
        reload      = (state_q == S_RELOAD);
    end

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = ar_addr_q;
    assign axi.arlen   = 8'd7;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = wb_addr_q;
    assign axi.awlen   = 8'd7;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.wstrb   = 4'hF;
    assign axi.wdata   = wb_word[wb_beat_q];

    // Request fields are captured once at acceptance; the cache may change them afterwards.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_addr_q <= '0;
            wb_addr_q <= '0;
            wb_buf_q  <= '0;
            wb_beat_q <= '0;
            rd_beat_q <= '0;
        end else begin
            if (accept) begin
                ar_addr_q <= rd_addr;
                wb_beat_q <= '0;
                rd_beat_q <= '0;
                if (wr_req) begin
                    wb_addr_q <= wr_addr;
                    wb_buf_q  <= cacheline_old;
                end
            end
            if (w_fire) wb_beat_q <= wb_beat_q + 3'd1;
            if (r_fire) rd_beat_q <= axi.rlast ? 3'd0 : rd_beat_q + 3'd1;
        end
    end

    // Each fill word has its own register; a short burst leaves the rest untouched.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_word
            logic [31:0] word_q;

            assign wb_word[gi] = wb_buf_q[32*gi +: 32];
            assign cacheline_new[32*gi +: 32] = word_q;

            always_ff @(posedge clk) begin
                if (!resetn)                                word_q <= '0;
                else if (r_fire && (rd_beat_q == 3'(gi)))   word_q <= axi.rdata;
            end
        end
    endgenerate
endmodule

// File: tb/tb_dcache_refill_bridge.sv
// Directed bench for dcache_refill_bridge: an AXI slave model driven cycle by cycle from one initial block.
module tb_dcache_refill_bridge;
    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [255:0] cacheline_old;
    logic         reload;
    logic [255:0] cacheline_new;

    dcache_refill_bridge_if axi ();

    dcache_refill_bridge #(.AXI_ID(4'd1)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .cacheline_old (cacheline_old),
        .reload        (reload),
        .cacheline_new (cacheline_new),
        .axi           (axi)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    int cyc, ar_cnt, aw_cnt, w_cnt, w_err, rbeat, reload_cnt, reload_cyc;
    int rlast_cyc, b_cyc, ar_first_cyc, aw_first_cyc, hold_err, post_err;
    bit timed_out, aborted;
    logic [31:0]  ar_addr_seen, aw_addr_seen;
    logic [7:0]   arlen_seen, awlen_seen;
    logic [2:0]   arsize_seen, awsize_seen;
    logic [1:0]   arburst_seen, awburst_seen;
    logic [3:0]   arid_seen, awid_seen;
    logic [255:0] line_seen;

    logic [255:0] exp_line;
    logic [255:0] old_line;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rlast   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
    endtask

    function automatic logic coin(input bit rnd);
        return rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    endfunction

    // One cache miss: raise the request, then act as the AXI slave at every falling edge.
    task automatic run_txn(input bit dirty, input logic [31:0] ra, input logic [31:0] wa,
                           input bit rnd, input int bdelay, input int r_hold, input int abort_beat);
        bit done, ar_wait, aw_wait, b_pend, gate;
        cyc = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; w_err = 0; rbeat = 0;
        reload_cnt = 0; reload_cyc = -1; rlast_cyc = -1; b_cyc = -1;
        ar_first_cyc = -1; aw_first_cyc = -1; hold_err = 0; post_err = 0;
        timed_out = 0; aborted = 0; line_seen = '0;
        done = 0; ar_wait = 0; aw_wait = 0; b_pend = 0;
        @(negedge clk);
        rd_req = 1'b1; rd_addr = ra; wr_req = dirty; wr_addr = wa; cacheline_old = old_line;
        clear_slave();
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                rd_addr = 32'hDEAD_0000; wr_addr = 32'hBEEF_0000; cacheline_old = '1;
            end
            if (ar_wait && !axi.arvalid) hold_err++;
            if (aw_wait && !axi.awvalid) hold_err++;
            if (reload) begin
                reload_cnt++;
                if (reload_cyc < 0) begin
                    reload_cyc = cyc;
                    line_seen  = cacheline_new;
                end
            end
            if (reload_cyc >= 0 && cyc > reload_cyc) begin
                if (axi.arvalid || axi.awvalid || reload) post_err++;
                if (cyc == reload_cyc + 1) begin rd_req = 1'b0; wr_req = 1'b0; end
                if (cyc == reload_cyc + 2) done = 1;
            end
            if (cyc >= 300) begin timed_out = 1; done = 1; end
            if (abort_beat >= 0 && axi.rready && rbeat == abort_beat) begin
                resetn = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
                clear_slave();
                aborted = 1; done = 1;
            end else begin
                if (axi.arvalid) begin
                    if (ar_first_cyc < 0) begin
                        ar_first_cyc = cyc; ar_addr_seen = axi.araddr; arlen_seen = axi.arlen;
                        arsize_seen = axi.arsize; arburst_seen = axi.arburst; arid_seen = axi.arid;
                    end
                    axi.arready = coin(rnd);
                    if (axi.arready) begin ar_cnt++; ar_wait = 0; end else ar_wait = 1;
                end else begin
                    axi.arready = 1'b0; ar_wait = 0;
                end
                if (axi.awvalid) begin
                    if (aw_first_cyc < 0) begin
                        aw_first_cyc = cyc; aw_addr_seen = axi.awaddr; awlen_seen = axi.awlen;
                        awsize_seen = axi.awsize; awburst_seen = axi.awburst; awid_seen = axi.awid;
                    end
                    axi.awready = coin(rnd);
                    if (axi.awready) begin aw_cnt++; aw_wait = 0; end else aw_wait = 1;
                end else begin
                    axi.awready = 1'b0; aw_wait = 0;
                end
                gate = (bdelay < 0) ? 1'b1 : (rlast_cyc >= 0 && cyc >= rlast_cyc + bdelay);
                axi.bvalid = b_pend && gate;
                if (axi.bvalid && axi.bready) begin b_cyc = cyc; b_pend = 0; end
                if (axi.wvalid) begin
                    axi.wready = coin(rnd);
                    if (axi.wready) begin
                        if (axi.wdata !== 32'hA0 + w_cnt || axi.wlast !== (w_cnt == 7) || axi.wstrb !== 4'hF)
                            w_err++;
                        if (axi.wlast) b_pend = 1;
                        w_cnt++;
                    end
                end else begin
                    axi.wready = 1'b0;
                end
                axi.rdata = 32'h11 * (rbeat + 1);
                axi.rlast = (rbeat == 7);
                axi.rvalid = (axi.rready && cyc >= r_hold && rbeat < 8) ? coin(rnd) : 1'b0;
                if (axi.rvalid) begin
                    if (rbeat == 7) rlast_cyc = cyc;
                    rbeat++;
                end
            end
        end
        $display("txn dirty=%0d rnd=%0d ar_cyc=%0d aw_cyc=%0d b_cyc=%0d rlast_cyc=%0d reload_cyc=%0d reloads=%0d aborted=%0d",
                 dirty, rnd, ar_first_cyc, aw_first_cyc, b_cyc, rlast_cyc, reload_cyc, reload_cnt, aborted);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_line = {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        old_line = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
        resetn = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; cacheline_old = '0;
        clear_slave();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_reload", reload, 1'b0);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid", axi.wvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_bready", axi.bready, 1'b0);
        check("rst_araddr", axi.araddr, 32'h0);
        check("rst_awaddr", axi.awaddr, 32'h0);
        check("rst_line", cacheline_new, 256'h0);
        resetn = 1'b1;

        // wr_req without rd_req must not start anything
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 32'h0000_5540;
        repeat (3) @(negedge clk);
        check("wronly_awvalid", axi.awvalid, 1'b0);
        check("wronly_arvalid", axi.arvalid, 1'b0);
        wr_req = 1'b0;

        // Clean miss, immediate responses, request held through RELOAD
        run_txn(1'b0, 32'h0000_1240, 32'h0, 1'b0, -1, 0, -1);
        check("clean_timeout", timed_out, 1'b0);
        check("clean_araddr", ar_addr_seen, 32'h0000_1240);
        check("clean_arlen", arlen_seen, 8'd7);
        check("clean_arsize", arsize_seen, 3'b010);
        check("clean_arburst", arburst_seen, 2'b01);
        check("clean_arid", arid_seen, 4'd1);
        check("clean_ar_cyc", ar_first_cyc, 1);
        check("clean_rlast_cyc", rlast_cyc, 9);
        check("clean_reload_cyc", reload_cyc, 10);
        check("clean_reload_cnt", reload_cnt, 1);
        check("clean_line", line_seen, exp_line);
        check("clean_no_aw", aw_cnt, 0);
        check("clean_no_w", w_cnt, 0);
        check("clean_post_idle", post_err, 0);

        // Dirty miss, immediate responses
        run_txn(1'b1, 32'h0000_1240, 32'h0000_3240, 1'b0, -1, 0, -1);
        check("dirty_timeout", timed_out, 1'b0);
        check("dirty_awaddr", aw_addr_seen, 32'h0000_3240);
        check("dirty_awlen", awlen_seen, 8'd7);
        check("dirty_awsize", awsize_seen, 3'b010);
        check("dirty_awburst", awburst_seen, 2'b01);
        check("dirty_awid", awid_seen, 4'd1);
        check("dirty_aw_cnt", aw_cnt, 1);
        check("dirty_w_beats", w_cnt, 8);
        check("dirty_w_data", w_err, 0);
        check("dirty_araddr", ar_addr_seen, 32'h0000_1240);
        check("dirty_b_seen", b_cyc, 10);
`ifdef DCACHE_WB_PARALLEL_EN
        check("dirty_ar_with_aw", ar_first_cyc, 1);
        check("dirty_reload_cyc", reload_cyc, 11);
`else
        check("dirty_b_before_ar", ar_first_cyc > b_cyc, 1'b1);
        check("dirty_reload_cyc", reload_cyc, 20);
`endif
        check("dirty_reload_cnt", reload_cnt, 1);
        check("dirty_line", line_seen, exp_line);
        check("dirty_post_idle", post_err, 0);

        // Dirty miss with random ready/valid toggling
        run_txn(1'b1, 32'h0000_7700, 32'h0000_9900, 1'b1, -1, 0, -1);
        check("rnd_timeout", timed_out, 1'b0);
        check("rnd_w_beats", w_cnt, 8);
        check("rnd_w_data", w_err, 0);
        check("rnd_hold", hold_err, 0);
        check("rnd_ar_cnt", ar_cnt, 1);
        check("rnd_aw_cnt", aw_cnt, 1);
        check("rnd_araddr", ar_addr_seen, 32'h0000_7700);
        check("rnd_awaddr", aw_addr_seen, 32'h0000_9900);
        check("rnd_reload_cnt", reload_cnt, 1);
        check("rnd_line", line_seen, exp_line);

        // Reset asserted at read beat 4, then the request is retried
        run_txn(1'b0, 32'h0000_1240, 32'h0, 1'b0, -1, 0, 4);
        check("abort_taken", aborted, 1'b1);
        @(negedge clk);
        check("abort_arvalid", axi.arvalid, 1'b0);
        check("abort_rready", axi.rready, 1'b0);
        check("abort_awvalid", axi.awvalid, 1'b0);
        check("abort_wvalid", axi.wvalid, 1'b0);
        check("abort_bready", axi.bready, 1'b0);
        check("abort_reload", reload, 1'b0);
        check("abort_araddr", axi.araddr, 32'h0);
        check("abort_line", cacheline_new, 256'h0);
        resetn = 1'b1;
        run_txn(1'b0, 32'h0000_2480, 32'h0, 1'b0, -1, 0, -1);
        check("retry_araddr", ar_addr_seen, 32'h0000_2480);
        check("retry_reload_cyc", reload_cyc, 10);
        check("retry_reload_cnt", reload_cnt, 1);
        check("retry_line", line_seen, exp_line);

`ifdef DCACHE_WB_PARALLEL_EN
        // bvalid arrives 5 cycles after rlast
        run_txn(1'b1, 32'h0000_1240, 32'h0000_3240, 1'b0, 5, 0, -1);
        check("par_late_b_cyc", b_cyc, rlast_cyc + 5);
        check("par_late_reload", reload_cyc, b_cyc + 1);
        check("par_late_reload_cnt", reload_cnt, 1);
        check("par_late_line", line_seen, exp_line);
        // bvalid arrives before the read data starts
        run_txn(1'b1, 32'h0000_1240, 32'h0000_3240, 1'b0, -1, 15, -1);
        check("par_early_b", b_cyc < rlast_cyc, 1'b1);
        check("par_early_reload", reload_cyc, rlast_cyc + 1);
        check("par_early_aw_cyc", aw_first_cyc, 1);
        check("par_early_line", line_seen, exp_line);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/dcache_refill_bridge.md
# dcache_refill_bridge

Memory-side responder for the data cache miss interface. It accepts the cache's level-held `rd_req`/`wr_req`, writes the victim line back as an 8-beat AXI write burst, and fetches the missing line as an 8-beat AXI read burst. It then returns the fetched line with a one-cycle `reload` pulse. It sits between the data cache and the CPU's AXI crossbar port.

## Interface
- `AXI_ID`, default 4'd1: constant ID driven on `arid`/`awid`.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `rd_req`  in  1  line fetch request, held by the cache until serviced.
- `rd_addr`  in  32  line-aligned fetch address (bits [4:0] = 0).
- `wr_req`  in  1  dirty-victim writeback request, valid only when `rd_req` is high.
- `wr_addr`  in  32  line-aligned victim address.
- `cacheline_old`  in  256  victim line data.
- `reload`  out  1  one-cycle pulse: `cacheline_new` is valid and must be written into the cache.
- `cacheline_new`  out  256  fetched line.
- `arid` / `araddr` / `arlen` / `arsize` / `arburst` / `arvalid`  out  4/32/8/3/2/1  AXI read address channel.
- `arready`  in  1  AXI read address ready.
- `rdata` / `rlast` / `rvalid`  in  32/1/1  AXI read data channel.
- `rready`  out  1  AXI read data ready.
- `awid` / `awaddr` / `awlen` / `awsize` / `awburst` / `awvalid`  out  4/32/8/3/2/1  AXI write address channel.
- `awready`  in  1  AXI write address ready.
- `wdata` / `wstrb` / `wlast` / `wvalid`  out  32/4/1/1  AXI write data channel.
- `wready`  in  1  AXI write data ready.
- `bvalid`  in  1  AXI write response valid.
- `bready`  out  1  AXI write response ready.

## Operation
- States: IDLE, AW, W, B, AR, R, RELOAD.
- IDLE, `rd_req`=1: latch `rd_addr` into `ar_addr_r`.
  - If `wr_req`=1: also latch `wr_addr` and `cacheline_old` into `wb_buf`, then go to AW.
  - Otherwise go to AR.
- AW: `awvalid`=1 until `awready` is sampled high, then go to W.
- W: `wvalid`=1 and `wdata`=`wb_buf[32*i+31:32*i]`, where `i` is a 3-bit beat counter starting at 0.
  - `i` advances on each `wvalid&wready`.
  - `wlast`=1 when `i`=7.
  - The handshake with `wlast` moves to B.
- B: `bready`=1. `bvalid` moves to AR. Response code is ignored.
- AR: `arvalid`=1 until `arready` is sampled high, then go to R.
- R: `rready`=1. On each `rvalid`, `rdata` is written to `line_r[32*j+31:32*j]` and `j` is incremented.
  - `rvalid&rlast` moves to RELOAD.
  - If `rlast` arrives with `j`≠7, the data is still accepted and RELOAD is entered; unwritten words keep their old contents.
- RELOAD: `reload`=1 for exactly one cycle, `cacheline_new`=`line_r`, then go to IDLE.
- The cache updates its tag at the RELOAD clock edge. Its `rd_req` therefore reflects the new line no earlier than the first IDLE cycle, so no request is accepted during RELOAD.
- Fixed fields:
  - `arlen`/`awlen`=8'd7, `arsize`/`awsize`=3'b010, `arburst`/`awburst`=2'b01 (INCR).
  - `wstrb`=4'hF.
  - `arid`/`awid`=`AXI_ID`.
- `araddr`/`awaddr` are driven from the latched registers, never from the live inputs.
- The cache's inputs may change after acceptance. The bridge uses only latched copies.

## Timing
- All outputs are registered or decoded from state. No combinational path from AXI inputs to AXI outputs except `wdata` selection by the counter.
- Reset: state=IDLE, all valid/ready outputs 0, `reload`=0, counters 0, `line_r`=0, `wb_buf`=0. All address outputs are 0.
- Reset mid-burst abandons the transaction; the interconnect is reset with the bridge.
- Minimum latency, clean miss with all ready/valid immediate: request seen in IDLE at cycle 0, `arvalid` at cycle 1, first R beat at cycle 2, `rlast` at cycle 9, `reload` at cycle 10.
- A dirty miss adds AW (1) + W (8) + B (1) cycles before AR.
- `rd_req` is ignored outside IDLE. `wr_req` without `rd_req` is ignored.

## Configuration
- `DCACHE_WB_PARALLEL_EN` defined:
  - On a dirty miss, AR and AW are both issued in the first cycle after acceptance. The read sub-FSM (AR,R) and write sub-FSM (AW,W,B) run independently.
  - RELOAD is entered only once `rlast` has been accepted and `bvalid` has been received, in either order.
  - A clean miss behaves exactly as without the macro.
  - This is safe because victim and fill addresses always differ in tag.
- Not defined: strictly sequential writeback-then-read as described in Operation.

## Test plan
- Clean miss at `rd_addr`=0x0000_1240, `wr_req`=0, memory words 0x11..0x88, immediate ready → `araddr`=0x0000_1240, `arlen`=7, `reload` at cycle 10, `cacheline_new`=0x88..0x11 (word 0 in LSBs), no AW activity.
- Dirty miss at `wr_addr`=0x0000_3240 with `cacheline_old` word i = 0xA0+i, `rd_addr`=0x0000_1240 → 8 W beats 0xA0..0xA7, `wlast` on beat 7, `bready` then `arvalid`, a single `reload`.
- `awready`, `wready` and `rvalid` each toggled randomly with a 50% duty → data order is unchanged, `awvalid`/`arvalid` are held until handshake, and `reload` is pulsed exactly once.
- `resetn` low during R beat 4, request then reissued → all valids drop the next cycle, and the retry completes with the correct line.
- Request still held during the RELOAD cycle → no second AR is issued in that cycle; the IDLE decision uses the next cycle's `rd_req`.
- With `DCACHE_WB_PARALLEL_EN`, `bvalid` delayed 5 cycles past `rlast` → `reload` asserts the cycle after `bvalid`. With `bvalid` before `rlast` → `reload` asserts the cycle after `rlast`.
